logic_gate_array: RTL and testbench
===================================

// Module: logic_gate_array
// PURPOSE
//   Parametrised successor to the single 2-input AND user module. Reduces NUM_IN
//   masked inputs to one output bit using a runtime-selectable gate mode.
//   Every input passes through a 2-flop synchroniser and a per-bit debouncer.
//   The result is registered, and a saturating counter tracks rising edges of
//   the output. Sits behind ui_in in the tile top level. Result goes to uo_out[0].
// PARAMETERS
//   NUM_IN           8   number of gate inputs (>=2)
//   DEBOUNCE_CYCLES  4   consecutive stable cycles before an input change is
//                        accepted; 0 = debounce bypassed
//   CNT_W            8   width of rise_count
// PORTS
//   clk          in   1        single clock; all state on rising edge
//   rst          in   1        synchronous reset, active-high
//   in_bits      in   NUM_IN   raw asynchronous gate inputs
//   mask         in   NUM_IN   1 = input participates; already synchronous, used unregistered
//   mode         in   3        gate mode: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 MAJ, 7 PASS
//   mode_load    in   1        latch mode into mode_reg on this edge
//   clear_count  in   1        zero rise_count on this edge
//   out          out  1        registered gate result
//   out_valid    out  1        out reflects current mode_reg
//   rise_count   out  CNT_W    saturating count of out 0->1 transitions
// BEHAVIOUR
//   Reset (rst=1 at edge): all of the following are zeroed.
//   - sync flops, debounced bits, debounce counters.
//   - mode_reg=0 (AND), out=0, out_valid=0, rise_count=0.
//   First edge with rst=0: out_valid<=1, out computed normally.
//   Reset mid-operation discards any pending debounce or mode change.
//   Synchroniser: s1<=in_bits, s2<=s1 per bit.
//   Debouncer (per bit), each edge:
//   - s2==stable: cnt<=0.
//   - Otherwise cnt<=cnt+1.
//   - When cnt==DEBOUNCE_CYCLES-1 and the bit still differs:
//     stable<=s2, cnt<=0.
//   - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
//   - DEBOUNCE_CYCLES=0: stable = s2 (combinational pass).
//   Latency: change held on in_bits appears on out 3+DEBOUNCE_CYCLES edges after
//   first sampling edge (3 when bypassed).
//   Reduction over e = stable with masked-off bits removed:
//   - AND/NAND: masked bits count as 1.
//   - OR/XOR/NOR/XNOR: masked bits count as 0.
//   - Empty set (mask=0): AND=1, OR=0, XOR=0; inverted modes are complements.
//   - MAJ: 1 iff (#ones among unmasked) > (#unmasked)/2, strict. Ties and the
//     empty set give 0. Popcount is sized to $clog2(NUM_IN+1) bits.
//   - PASS: out = stable bit at index 0 (mask ignored).
//   out<=f(mode_reg, stable, mask) every edge. mask changes show on out next edge.
//   mode_load=1 at edge: mode_reg<=mode, out_valid<=0, out keeps old-mode value.
//   Next edge: out<=result under new mode, out_valid<=1.
//   - mode_load held high keeps out_valid low.
//   - Back-to-back loads: the last load wins.
//   rise_count counts every edge where out goes 0->1, including rises caused by a
//   mode change.
//   - Saturates at 2^CNT_W-1; no wrap.
//   - clear_count has priority: a rise on the same edge is dropped, count=0.
// TESTING
//   1 NUM_IN=2, D=0, mode AND, mask=11: in 00,01,10,11 held 5 cycles each
//     -> out 0,0,0,1, each 3 edges after change; rise_count=1.
//   2 D=4: pulse in_bits[0] high for 3 cycles -> out unchanged.
//     Hold it 4+ cycles -> out changes exactly 7 edges after first sample.
//   3 NUM_IN=8, in=8'b1011_0001, mask=8'hFF, cycle modes 0..7
//     -> out 0,1,0,1,0,1,0,1 (MAJ: 4 of 8 = tie -> 0).
//     out_valid low exactly 1 cycle per load.
//   4 mask=8'h00: AND->1, OR->0, XOR->0, NAND->0, MAJ->0.
//     mask=8'h0F, in=8'h0F, AND -> 1.
//   5 CNT_W=3: toggle out 9 times -> rise_count saturates at 7.
//     clear_count on a rising edge -> 0, not 1.
//   6 rst pulsed mid-debounce and mid-mode_load
//     -> all outputs 0 on the next edge, mode_reg=AND, pending change lost.

Source files
------------

// File: rtl/logic_gate_array.sv
// logic_gate_array: masked NUM_IN-input reduction with runtime-selectable gate
// mode. Each raw input goes through a 2-flop synchroniser and a per-bit debouncer.
// The result is registered, and a saturating counter tracks rising edges of out.
module logic_gate_array #(
  parameter int NUM_IN          = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] in_bits,
  input  logic [NUM_IN-1:0] mask,
  input  logic [2:0]        mode,
  input  logic              mode_load,
  input  logic              clear_count,
  output logic              out,
  output logic              out_valid,
  output logic [CNT_W-1:0]  rise_count
);

  localparam int PC_W = $clog2(NUM_IN + 1);
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_XOR  = 3'd2;
  localparam logic [2:0] MODE_NAND = 3'd3;
  localparam logic [2:0] MODE_NOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;
  localparam logic [2:0] MODE_MAJ  = 3'd6;
  localparam logic [2:0] MODE_PASS = 3'd7;

  logic [NUM_IN-1:0] s1_q, s1_d;
  logic [NUM_IN-1:0] s2_q, s2_d;
  logic [NUM_IN-1:0] stable_q, stable_d;
  logic [DB_W-1:0]   cnt_q [NUM_IN];
  logic [DB_W-1:0]   cnt_d [NUM_IN];
  logic [NUM_IN-1:0] stable_eff;
  logic [2:0]        mode_reg_q, mode_reg_d;
  logic              out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  rise_count_q, rise_count_d;

  // Masked reduction. Masked-off bits act as the identity of each gate so the
  // empty set yields AND=1, OR=0, XOR=0; MAJ is strict (ties and empty give 0).
  function automatic logic gate_eval(input logic [2:0]        m,
                                     input logic [NUM_IN-1:0] e,
                                     input logic [NUM_IN-1:0] msk);
    logic [PC_W-1:0] ones;
    logic [PC_W-1:0] n;
    logic            r;
    ones = '0;
    n    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      ones = ones + PC_W'(e[i] & msk[i]);
      n    = n + PC_W'(msk[i]);
    end
    r = 1'b0;
    case (m)
      MODE_AND:  r = &(e | ~msk);
      MODE_OR:   r = |(e & msk);
      MODE_XOR:  r = ^(e & msk);
      MODE_NAND: r = ~&(e | ~msk);
      MODE_NOR:  r = ~|(e & msk);
      MODE_XNOR: r = ~^(e & msk);
      MODE_MAJ:  r = ({ones, 1'b0} > {1'b0, n});
      MODE_PASS: r = e[0];
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // Synchroniser and per-bit debouncer: a change is accepted only after s2 has
  // differed from the accepted value for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    s1_d     = in_bits;
    s2_d     = s1_q;
    stable_d = stable_q;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    stable_eff = (DEBOUNCE_CYCLES == 0) ? s2_q : stable_q;
  end

  // Output, mode register and saturating rise counter; clear beats a rise.
  always_comb begin
    out_d        = gate_eval(mode_reg_q, stable_eff, mask);
    out_valid_d  = ~mode_load;
    mode_reg_d   = mode_load ? mode : mode_reg_q;
    rise_count_d = rise_count_q;
    if (clear_count) begin
      rise_count_d = '0;
    end else if (out_d && !out_q && (rise_count_q != {CNT_W{1'b1}})) begin
      rise_count_d = rise_count_q + 1'b1;
    end
  end

  // State update; reset clears everything, including pending debounce/mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      stable_q     <= '0;
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
      mode_reg_q   <= MODE_AND;
      out_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      rise_count_q <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      stable_q     <= stable_d;
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= cnt_d[i];
      mode_reg_q   <= mode_reg_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      rise_count_q <= rise_count_d;
    end
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign rise_count = rise_count_q;

endmodule

// File: tb/tb_logic_gate_array.sv
// Bench for logic_gate_array: an 8-input debounced instance checked every cycle
// against a behavioural model, plus a 2-input bypass instance for latency.
module tb_logic_gate_array;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_bits, mask;
  logic [2:0] mode;
  logic       mode_load, clear_count;
  logic       out, out_valid;
  logic [2:0] rise_count;

  logic [1:0] b_in, b_mask;
  logic       b_out, b_valid;
  logic [7:0] b_rc;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_s1, m_s2, m_stable;
  logic [7:0] m_win [4];
  logic [2:0] m_mode;
  logic       m_out, m_vld;
  int         m_rc;

  logic [7:0] exp_tab;

  always #5 clk = ~clk;

  logic_gate_array #(.NUM_IN(8), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_bits(in_bits), .mask(mask), .mode(mode),
    .mode_load(mode_load), .clear_count(clear_count), .out(out),
    .out_valid(out_valid), .rise_count(rise_count));

  logic [2:0] b_mode = 3'd0;
  logic       b_load = 1'b0;
  logic       b_clr  = 1'b0;
  logic_gate_array #(.NUM_IN(2), .DEBOUNCE_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_bits(b_in), .mask(b_mask), .mode(b_mode),
    .mode_load(b_load), .clear_count(b_clr), .out(b_out),
    .out_valid(b_valid), .rise_count(b_rc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Gate result from the rules: count participating ones and participants.
  function automatic logic ref_gate(input logic [2:0] m, input logic [7:0] e,
                                    input logic [7:0] msk);
    int ones = 0;
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      if (msk[i]) begin
        n++;
        if (e[i]) ones++;
      end
    end
    case (m)
      3'd0: return ones == n;
      3'd1: return ones > 0;
      3'd2: return (ones % 2) == 1;
      3'd3: return ones != n;
      3'd4: return ones == 0;
      3'd5: return (ones % 2) == 0;
      3'd6: return 2 * ones > n;
      default: return e[0];
    endcase
  endfunction

  // Model advance for one clock edge. A bit flips once its last four
  // synchronised samples all disagree with the accepted value.
  task automatic model_step();
    logic nout;
    logic flip;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_mode = 3'd0;
      m_out = 1'b0; m_vld = 1'b0; m_rc = 0;
      for (int j = 0; j < 4; j++) m_win[j] = '0;
    end else begin
      nout = ref_gate(m_mode, m_stable, mask);
      for (int j = 0; j < 3; j++) m_win[j] = m_win[j+1];
      m_win[3] = m_s2;
      for (int b = 0; b < 8; b++) begin
        flip = 1'b1;
        for (int j = 0; j < 4; j++) if (m_win[j][b] == m_stable[b]) flip = 1'b0;
        if (flip) m_stable[b] = ~m_stable[b];
      end
      if (clear_count) m_rc = 0;
      else if (nout && !m_out && m_rc < 7) m_rc++;
      m_out = nout;
      m_vld = !mode_load;
      if (mode_load) m_mode = mode;
      m_s2 = m_s1;
      m_s1 = in_bits;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_out", 32'(out), 32'(m_out));
    check("model_valid", 32'(out_valid), 32'(m_vld));
    check("model_rc", 32'(rise_count), 32'(m_rc));
  endtask

  task automatic load_mode(input logic [2:0] m);
    mode = m; mode_load = 1'b1;
    cyc();
    check("load_valid_low", 32'(out_valid), 32'(0));
    mode_load = 1'b0;
    cyc();
    check("load_valid_high", 32'(out_valid), 32'(1));
  endtask

  initial begin
    rst = 1'b1; in_bits = '0; mask = 8'hFF; mode = '0;
    mode_load = 1'b0; clear_count = 1'b0; b_in = '0; b_mask = 2'b11;
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_mode = '0; m_out = 0; m_vld = 0; m_rc = 0;
    for (int j = 0; j < 4; j++) m_win[j] = '0;
    @(negedge clk);
    cyc(); cyc();
    check("rst_out", 32'(out), 32'(0));
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_rc", 32'(rise_count), 32'(0));
    check("rst_b_out", 32'(b_out), 32'(0));
    rst = 1'b0;

    // Bypass instance, AND over two inputs: new value lands 3 edges later.
    for (int p = 0; p < 4; p++) begin
      logic oldv, newv;
      oldv = (p == 0) ? 1'b0 : 1'b0;
      newv = (p == 3);
      b_in = 2'(p);
      for (int k = 1; k <= 5; k++) begin
        cyc();
        if (p == 0 && k == 1) check("first_valid", 32'(out_valid), 32'(1));
        check($sformatf("bypass_p%0d_k%0d", p, k), 32'(b_out),
              32'((k >= 3) ? newv : oldv));
      end
    end
    check("bypass_rc", 32'(b_rc), 32'(1));

    // Debounce: a 3-cycle glitch is rejected, a held change takes 7 edges.
    load_mode(3'd7);
    in_bits = 8'h01;
    repeat (3) cyc();
    in_bits = 8'h00;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("glitch_out", 32'(out), 32'(0));
    end
    in_bits = 8'h01;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("latency_k%0d", k), 32'(out), 32'(k >= 7));
    end

    // All eight modes on 1011_0001 with full mask.
    in_bits = 8'hB1; mask = 8'hFF;
    repeat (10) cyc();
    exp_tab = 8'hAA;
    for (int m = 0; m < 8; m++) begin
      load_mode(3'(m));
      check($sformatf("mode%0d_full", m), 32'(out), 32'(exp_tab[m]));
    end

    // Empty mask: identities and complements; PASS ignores mask.
    mask = 8'h00;
    exp_tab = 8'hB1;
    for (int m = 0; m < 8; m++) begin
      load_mode(3'(m));
      check($sformatf("mode%0d_empty", m), 32'(out), 32'(exp_tab[m]));
    end
    mask = 8'h0F; in_bits = 8'h0F;
    load_mode(3'd0);
    repeat (10) cyc();
    check("and_partial", 32'(out), 32'(1));

    // Saturation at 7 and clear priority over a simultaneous rise.
    mask = 8'h10;
    clear_count = 1'b1;
    cyc();
    clear_count = 1'b0;
    for (int r = 0; r < 9; r++) begin
      mask = 8'h00; cyc();
      mask = 8'h10; cyc();
    end
    check("rc_saturate", 32'(rise_count), 32'(7));
    mask = 8'h00; clear_count = 1'b1;
    cyc();
    check("clear_prio_rc", 32'(rise_count), 32'(0));
    check("clear_prio_out", 32'(out), 32'(1));
    clear_count = 1'b0;

    // Reset during a pending debounce and a mode load.
    mask = 8'hF0; in_bits = 8'hF0;
    repeat (3) cyc();
    mode = 3'd1; mode_load = 1'b1; rst = 1'b1;
    cyc();
    check("midrst_out", 32'(out), 32'(0));
    check("midrst_valid", 32'(out_valid), 32'(0));
    check("midrst_rc", 32'(rise_count), 32'(0));
    rst = 1'b0; mode_load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check($sformatf("postrst_k%0d", k), 32'(out), 32'(k >= 7));
    end
    mask = 8'hFF;
    cyc();
    check("postrst_mode_and", 32'(out), 32'(0));

    // Randomised traffic against the model.
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(5) == 0) in_bits = 8'($urandom);
      if ($urandom_range(7) == 0) mask = 8'($urandom);
      mode = 3'($urandom);
      mode_load = ($urandom_range(9) == 0);
      clear_count = ($urandom_range(19) == 0);
      rst = ($urandom_range(149) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
